// File: rtl/irq_arbiter.sv
// ============================================================================
// Module   : irq_arbiter
// Brief    : Edge-detecting interrupt collector with round-robin MSI arbiter,
//            per-channel overflow tracking and post-ack holdoff gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_arbiter #(
    parameter int NUM_CHANNELS   = 4,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [NUM_CHANNELS-1:0]         i_irq,
    input  logic [NUM_CHANNELS-1:0]         i_mask,
    input  logic                            i_msi_ack,
    input  logic                            i_overflow_clr,
    output logic                            o_msi_req,
    output logic [$clog2(NUM_CHANNELS)-1:0] o_msi_vector,
    output logic [NUM_CHANNELS-1:0]         o_pending,
    output logic [NUM_CHANNELS-1:0]         o_overflow
);

    localparam int          VEC_W     = $clog2(NUM_CHANNELS);
    localparam logic [15:0] c_HOLDOFF = 16'(HOLDOFF_CYCLES);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_HOLDOFF_ST = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic [NUM_CHANNELS-1:0] r_prev;
    logic [NUM_CHANNELS-1:0] r_pending;
    logic [NUM_CHANNELS-1:0] r_overflow;
    logic [VEC_W-1:0]        r_vector;
    logic [VEC_W-1:0]        r_last_grant;
    logic [15:0]             r_count;

    logic [NUM_CHANNELS-1:0] w_event;
    logic [NUM_CHANNELS-1:0] w_eligible;
    logic [NUM_CHANNELS-1:0] w_clr;
    logic                    w_ack;
    logic                    w_found;
    logic [VEC_W-1:0]        w_winner;
    int                      w_idx;

    assign w_event    = i_irq & ~r_prev;
    assign w_eligible = r_pending & ~i_mask;
    assign w_ack      = (r_state == c_REQ) && i_msi_ack;

    always_comb begin
        w_clr = '0;
        if (w_ack) begin
            w_clr[r_vector] = 1'b1;
        end
    end

    // Round-robin: scan upward from the channel after the last grant, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            w_idx = int'(r_last_grant) + k;
            if (w_idx >= NUM_CHANNELS) begin
                w_idx = w_idx - NUM_CHANNELS;
            end
            if (!w_found && w_eligible[w_idx]) begin
                w_found  = 1'b1;
                w_winner = VEC_W'(w_idx);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_next_state = c_REQ;
                end
            end
            c_REQ: begin
                if (i_msi_ack) begin
                    w_next_state = (c_HOLDOFF == 16'd0) ? c_IDLE : c_HOLDOFF_ST;
                end
            end
            c_HOLDOFF_ST: begin
                if (r_count == 16'd1) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        o_msi_req    = (r_state == c_REQ);
        o_msi_vector = r_vector;
    end

    // A coincident event re-sets pending over the ack clear and is not an overflow.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_prev       <= '0;
            r_pending    <= '0;
            r_overflow   <= '0;
            r_vector     <= '0;
            r_last_grant <= VEC_W'(NUM_CHANNELS - 1);
            r_count      <= 16'd0;
        end else begin
            r_prev     <= i_irq;
            r_pending  <= (r_pending & ~w_clr) | w_event;
            r_overflow <= (r_overflow & ~{NUM_CHANNELS{i_overflow_clr}})
                        | (w_event & r_pending & ~w_clr);
            if ((r_state == c_IDLE) && w_found) begin
                r_vector <= w_winner;
            end
            if (w_ack) begin
                r_last_grant <= r_vector;
                r_count      <= c_HOLDOFF;
            end else if ((r_state == c_HOLDOFF_ST) && (r_count != 16'd0)) begin
                r_count <= r_count - 16'd1;
            end
        end
    end

    assign o_pending  = r_pending;
    assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
// ============================================================================
// Module   : tb_irq_arbiter
// Brief    : Scoreboard bench for irq_arbiter (holdoff 16 and holdoff 0 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_arbiter;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_GAP  = 2;

    typedef struct {
        logic [3:0] prev;
        logic [3:0] pend;
        logic [3:0] ovf;
        int         phase;
        int         vec;
        int         last;
        int         gap;
    } mdl_t;

    typedef struct {
        logic       req;
        logic [1:0] vec;
        logic [3:0] pend;
        logic [3:0] ovf;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic [3:0] i_irq = '0;
    logic [3:0] i_mask = '0;
    logic       i_msi_ack = 1'b0;
    logic       i_overflow_clr = 1'b0;

    logic       req0, req1;
    logic [1:0] vec0, vec1;
    logic [3:0] pend0, pend1, ovf0, ovf1;

    int vectors = 0;
    int miscompares = 0;

    mdl_t m0, m1;
    exp_t q0[$], q1[$];
    int   g0[$], g1[$];

    always #2.5 i_clk = ~i_clk;

    irq_arbiter #(.NUM_CHANNELS(4), .HOLDOFF_CYCLES(16)) u_dut0 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_irq(i_irq), .i_mask(i_mask),
        .i_msi_ack(i_msi_ack), .i_overflow_clr(i_overflow_clr),
        .o_msi_req(req0), .o_msi_vector(vec0), .o_pending(pend0), .o_overflow(ovf0)
    );

    irq_arbiter #(.NUM_CHANNELS(4), .HOLDOFF_CYCLES(0)) u_dut1 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_irq(i_irq), .i_mask(i_mask),
        .i_msi_ack(i_msi_ack), .i_overflow_clr(i_overflow_clr),
        .o_msi_req(req1), .o_msi_vector(vec1), .o_pending(pend1), .o_overflow(ovf1)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural rules: events latch, lost events flag overflow, grants rotate.
    function automatic void mdl_step(inout mdl_t m, input int hold,
                                     input logic [3:0] irq, input logic [3:0] mask,
                                     input logic ack, input logic clr, input logic rstn,
                                     output bit new_grant, output int gnt);
        mdl_t       n;
        logic [3:0] ev;
        bit         done;
        int         c;
        n = m;
        new_grant = 0;
        gnt = 0;
        if (!rstn) begin
            n.prev = '0; n.pend = '0; n.ovf = '0;
            n.phase = PH_IDLE; n.vec = 0; n.last = 3; n.gap = 0;
        end else begin
            ev   = irq & ~m.prev;
            done = (m.phase == PH_REQ) && ack;
            n.prev = irq;
            n.ovf  = clr ? 4'b0 : m.ovf;
            for (int i = 0; i < 4; i++) begin
                if (done && m.vec == i) n.pend[i] = 1'b0;
                if (ev[i]) begin
                    if (m.pend[i] && !(done && m.vec == i)) n.ovf[i] = 1'b1;
                    n.pend[i] = 1'b1;
                end
            end
            case (m.phase)
                PH_IDLE: begin
                    for (int k = 1; k <= 4; k++) begin
                        c = (m.last + k) % 4;
                        if (m.pend[c] && !mask[c]) begin
                            n.phase = PH_REQ; n.vec = c;
                            new_grant = 1; gnt = c;
                            break;
                        end
                    end
                end
                PH_REQ: begin
                    if (ack) begin
                        n.last = m.vec;
                        if (hold == 0) n.phase = PH_IDLE;
                        else begin n.phase = PH_GAP; n.gap = hold; end
                    end
                end
                default: begin
                    n.gap = m.gap - 1;
                    if (n.gap == 0) n.phase = PH_IDLE;
                end
            endcase
        end
        m = n;
    endfunction

    function automatic exp_t to_exp(mdl_t m);
        exp_t e;
        e.req  = (m.phase == PH_REQ);
        e.vec  = 2'(m.vec);
        e.pend = m.pend;
        e.ovf  = m.ovf;
        return e;
    endfunction

    task automatic cyc(input logic [3:0] irq, input logic [3:0] mask,
                       input logic ack, input logic clr, input logic rstn);
        bit ng;
        int g;
        @(negedge i_clk);
        i_irq = irq; i_mask = mask; i_msi_ack = ack;
        i_overflow_clr = clr; i_reset_n = rstn;
        mdl_step(m0, 16, irq, mask, ack, clr, rstn, ng, g);
        if (ng) g0.push_back(g);
        q0.push_back(to_exp(m0));
        mdl_step(m1, 0, irq, mask, ack, clr, rstn, ng, g);
        if (ng) g1.push_back(g);
        q1.push_back(to_exp(m1));
    endtask

    task automatic idle(input int n, input logic [3:0] mask);
        for (int i = 0; i < n; i++) cyc(4'b0, mask, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_req(input logic [3:0] mask, input int max);
        for (int i = 0; i < max; i++) begin
            if (m0.phase == PH_REQ) return;
            cyc(4'b0, mask, 1'b0, 1'b0, 1'b1);
        end
        chk("wait_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack_wait(input logic [3:0] mask, input logic [3:0] irq_at_ack, input int max);
        wait_req(mask, max);
        cyc(irq_at_ack, mask, 1'b1, 1'b0, 1'b1);
    endtask

    // Monitor: every cycle's outputs against the queued prediction, and each
    // new request's vector against the predicted grant order.
    initial begin
        exp_t e;
        logic p0 = 1'b0, p1 = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("d0_req", 32'(req0), 32'(e.req));
                chk("d0_vector", 32'(vec0), 32'(e.vec));
                chk("d0_pending", 32'(pend0), 32'(e.pend));
                chk("d0_overflow", 32'(ovf0), 32'(e.ovf));
                if (req0 === 1'b1 && !p0) begin
                    if (g0.size() == 0) chk("d0_unexpected_grant", 32'(vec0), 32'hFF);
                    else chk("d0_grant_order", 32'(vec0), 32'(g0.pop_front()));
                end
                p0 = (req0 === 1'b1);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("d1_req", 32'(req1), 32'(e.req));
                chk("d1_vector", 32'(vec1), 32'(e.vec));
                chk("d1_pending", 32'(pend1), 32'(e.pend));
                chk("d1_overflow", 32'(ovf1), 32'(e.ovf));
                if (req1 === 1'b1 && !p1) begin
                    if (g1.size() == 0) chk("d1_unexpected_grant", 32'(vec1), 32'hFF);
                    else chk("d1_grant_order", 32'(vec1), 32'(g1.pop_front()));
                end
                p1 = (req1 === 1'b1);
            end
        end
    end

    initial begin
        m0 = '{default: 0};
        m1 = '{default: 0};
        repeat (3) cyc(4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        idle(2, 4'b0);

        // single event on channel 2, then the holdoff gap
        cyc(4'b0100, 4'b0, 1'b0, 1'b0, 1'b1);
        ack_wait(4'b0, 4'b0, 10);
        idle(20, 4'b0);

        // round-robin bursts
        cyc(4'b1011, 4'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) ack_wait(4'b0, 4'b0, 30);
        idle(20, 4'b0);
        cyc(4'b1001, 4'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) ack_wait(4'b0, 4'b0, 30);
        idle(20, 4'b0);

        // mask holds delivery but not latching; mask during REQ does not retract
        cyc(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1);
        idle(5, 4'b0010);
        idle(1, 4'b0);
        wait_req(4'b0, 5);
        idle(2, 4'b1111);
        ack_wait(4'b1111, 4'b0, 5);
        idle(20, 4'b0);

        // overflow, clear, and clear coincident with a new overflow
        cyc(4'b0001, 4'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 4'b0);
        cyc(4'b0001, 4'b0, 1'b0, 1'b0, 1'b1);
        idle(1, 4'b0);
        cyc(4'b0000, 4'b0, 1'b0, 1'b1, 1'b1);
        idle(1, 4'b0);
        cyc(4'b0001, 4'b0, 1'b0, 1'b1, 1'b1);
        idle(1, 4'b0);
        ack_wait(4'b0, 4'b0, 5);
        idle(20, 4'b0);

        // event on the ack cycle of the same channel, then reset mid-REQ
        cyc(4'b0100, 4'b0, 1'b0, 1'b0, 1'b1);
        ack_wait(4'b0, 4'b0100, 10);
        idle(1, 4'b0);
        wait_req(4'b0, 30);
        cyc(4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 4'b0);

        // level held across reset release counts once
        cyc(4'b0001, 4'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'b0001, 4'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) cyc(4'b0001, 4'b0, 1'b0, 1'b0, 1'b1);
        ack_wait(4'b0, 4'b0, 5);
        idle(20, 4'b0);

        // ack pulses while idle are ignored
        repeat (3) cyc(4'b0, 4'b0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            cyc(4'($urandom),
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 299) != 0));
        end

        idle(2, 4'b0);
        @(posedge i_clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
